// File: rtl/piso_shift_transmitter.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out MSB-first. Optional even-parity bit: PISO_PARITY_EN.
module piso_shift_transmitter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             shift_out,
    output logic             frame_active,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               shift_out_q, shift_out_d;
    logic               frame_active_q, frame_active_d;
    logic               done_q, done_d;
`ifdef PISO_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic last_bit;
    logic handshake;

    // cnt_q counts frame bits still to be driven, including the one on shift_out.
    assign last_bit   = (state_q == SHIFT) && (cnt_q == CNT_W'(1));
    assign load_ready = (state_q == IDLE) || last_bit;
    assign handshake  = load_valid && load_ready;

    always_comb begin
        state_d        = state_q;
        sreg_d         = sreg_q;
        cnt_d          = cnt_q;
        shift_out_d    = 1'b0;
        frame_active_d = 1'b0;
        done_d         = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d       = parity_q;
`endif
        if (handshake) begin
            state_d        = SHIFT;
            sreg_d         = {data_in[WIDTH-2:0], 1'b0};
            cnt_d          = CNT_W'(FRAME_LEN);
            shift_out_d    = data_in[WIDTH-1];
            frame_active_d = 1'b1;
`ifdef PISO_PARITY_EN
            parity_d       = ^data_in;
`endif
        end else if (state_q == SHIFT && !last_bit) begin
            cnt_d          = cnt_q - 1'b1;
            sreg_d         = {sreg_q[WIDTH-2:0], 1'b0};
            shift_out_d    = sreg_q[WIDTH-1];
            frame_active_d = 1'b1;
            done_d         = (cnt_d == CNT_W'(1));
`ifdef PISO_PARITY_EN
            if (cnt_d == CNT_W'(1)) shift_out_d = parity_q;
`endif
        end else if (last_bit) begin
            state_d = IDLE;
            cnt_d   = '0;
            sreg_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= IDLE;
            sreg_q         <= '0;
            cnt_q          <= '0;
            shift_out_q    <= 1'b0;
            frame_active_q <= 1'b0;
            done_q         <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q       <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            sreg_q         <= sreg_d;
            cnt_q          <= cnt_d;
            shift_out_q    <= shift_out_d;
            frame_active_q <= frame_active_d;
            done_q         <= done_d;
`ifdef PISO_PARITY_EN
            parity_q       <= parity_d;
`endif
        end
    end

    assign shift_out    = shift_out_q;
    assign frame_active = frame_active_q;
    assign done         = done_q;

endmodule
